amiga_wcs_dram_ctrl: RTL and testbench

//  Parametrised successor of the A1000 writable-control-store daughterboard, as a synchronous DRAM controller.

---
 rtl/amiga_wcs_dram_ctrl_pkg.sv | 28 ++
 rtl/amiga_wcs_dram_ctrl_refresh_timer.sv | 36 +++
 rtl/amiga_wcs_dram_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_amiga_wcs_dram_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amiga_wcs_dram_ctrl_pkg.sv
// Shared types and helpers for the WCS DRAM controller: FSM states, byte-lane
// positions within a bank's CAS pair, and width helpers.
package amiga_wcs_dram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_ACK,
    ST_PRE,
    ST_REF_CAS,
    ST_REF_RAS
  } dram_state_e;

  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  function automatic int bank_bits(input int banks);
    return (banks > 1) ? $clog2(banks) : 0;
  endfunction

  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/amiga_wcs_dram_ctrl_refresh_timer.sv
// Free-running refresh interval timer; raises a sticky pending flag every
// REFRESH_DIV cycles until the controller accepts the refresh.
module amiga_wcs_dram_ctrl_refresh_timer #(
  parameter int REFRESH_DIV = 109
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ack,
  output logic o_pending
);

  localparam int W = $clog2(REFRESH_DIV);
  localparam logic [W-1:0] RELOAD = W'(REFRESH_DIV - 1);

  logic [W-1:0] r_cnt;
  logic         r_pending;

  // A new interval expiring on the accept cycle must not be lost, so set wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= RELOAD;
      r_pending <= 1'b0;
    end else begin
      if (r_cnt == '0) begin
        r_cnt     <= RELOAD;
        r_pending <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
        if (i_ack) r_pending <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/amiga_wcs_dram_ctrl.sv
// Synchronous DRAM sequencer for decoded 68000 bus cycles: row/column mux,
// per-bank byte CAS decode, CBR refresh and a sticky write-protect latch.
//
// state   | meaning
// IDLE    | waiting; refresh has priority over a bus request
// ROW     | _RAS low with row address, T_RCD cycles
// COL     | _CAS low with column address, T_CAS cycles
// ACK     | _DTACK low until the bus drops REQ
// PRE     | precharge, T_RP cycles
// REF_CAS | all _CAS low with _RAS high, one cycle
// REF_RAS | _RAS and all _CAS low, T_CAS+1 cycles
module amiga_wcs_dram_ctrl
  import amiga_wcs_dram_ctrl_pkg::*;
#(
  parameter int ROW_BITS    = 8,
  parameter int BANKS       = 2,
  parameter int T_RCD       = 2,
  parameter int T_CAS       = 2,
  parameter int T_RP        = 2,
  parameter int REFRESH_DIV = 109,
  localparam int BANK_BITS  = bank_bits(BANKS),
  localparam int AW         = 2*ROW_BITS + BANK_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req,
  input  logic [AW-1:0]       i_a,
  input  logic                i_rw,
  input  logic                i_uds_n,
  input  logic                i_lds_n,
  input  logic [15:0]         i_wd,
  output logic [15:0]         o_rd,
  output logic                o_dtack_n,
  input  logic                i_wp_set,
  output logic                o_wpro,
  output logic [ROW_BITS-1:0] o_ma,
  output logic                o_ras_n,
  output logic [2*BANKS-1:0]  o_cas_n,
  output logic                o_we_n,
  output logic [15:0]         o_dq_o,
  output logic                o_dq_oe,
  input  logic [15:0]         i_dq_i
);

  localparam int BW = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int CW = $clog2(max3(T_RCD, T_CAS + 1, T_RP) + 1);

  dram_state_e         r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [ROW_BITS-1:0] r_row, r_col;
  logic [BW-1:0]       r_bank;
  logic                r_rw, r_uds_n, r_lds_n, r_drop, r_wpro;
  logic [15:0]         r_wd, r_rd;
  logic [BW-1:0]       w_bank;
  logic                w_pending, w_ref_ack, w_start, w_wr_en;
  logic [2*BANKS-1:0]  w_cas_sel_n;

  if (BANK_BITS > 0) begin : g_bank
    assign w_bank = i_a[AW-1 -: BANK_BITS];
  end else begin : g_nobank
    assign w_bank = '0;
  end

  assign w_ref_ack = (r_state == ST_IDLE) && w_pending;
  assign w_start   = (r_state == ST_IDLE) && !w_pending && i_req;
  assign w_wr_en   = !r_rw && !r_drop;

  amiga_wcs_dram_ctrl_refresh_timer #(.REFRESH_DIV(REFRESH_DIV)) u_refresh_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ack     (w_ref_ack),
    .o_pending (w_pending)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != w_next) begin
        case (w_next)
          ST_ROW:     r_cnt <= CW'(T_RCD - 1);
          ST_COL:     r_cnt <= CW'(T_CAS - 1);
          ST_PRE:     r_cnt <= CW'(T_RP - 1);
          ST_REF_RAS: r_cnt <= CW'(T_CAS);
          default:    r_cnt <= '0;
        endcase
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_pending) w_next = ST_REF_CAS;
                  else if (i_req) w_next = ST_ROW;
      ST_ROW:     if (r_cnt == '0) w_next = ST_COL;
      ST_COL:     if (r_cnt == '0) w_next = ST_ACK;
      ST_ACK:     if (!i_req) w_next = ST_PRE;
      ST_PRE:     if (r_cnt == '0) w_next = ST_IDLE;
      ST_REF_CAS: w_next = ST_REF_RAS;
      ST_REF_RAS: if (r_cnt == '0) w_next = ST_PRE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Protection is sampled at cycle start so a mid-cycle WP_SET cannot truncate a write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row   <= '0;
      r_col   <= '0;
      r_bank  <= '0;
      r_rw    <= 1'b1;
      r_uds_n <= 1'b1;
      r_lds_n <= 1'b1;
      r_drop  <= 1'b0;
      r_wd    <= '0;
      r_rd    <= '0;
      r_wpro  <= 1'b0;
    end else begin
      if (w_start) begin
        r_bank  <= w_bank;
        r_row   <= i_a[2*ROW_BITS-1:ROW_BITS];
        r_col   <= i_a[ROW_BITS-1:0];
        r_rw    <= i_rw;
        r_uds_n <= i_uds_n;
        r_lds_n <= i_lds_n;
        r_wd    <= i_wd;
        r_drop  <= !i_rw && r_wpro;
      end
      if (r_state == ST_COL && r_cnt == '0 && r_rw) r_rd <= i_dq_i;
      if (i_wp_set) r_wpro <= 1'b1;
    end
  end

  always_comb begin
    w_cas_sel_n = '1;
    for (int b = 0; b < BANKS; b++) begin
      if (r_bank == BW'(b) && !(!r_rw && r_drop)) begin
        w_cas_sel_n[2*b + LANE_LO] = r_lds_n;
        w_cas_sel_n[2*b + LANE_HI] = r_uds_n;
      end
    end
  end

  always_comb begin
    o_ras_n   = 1'b1;
    o_cas_n   = '1;
    o_we_n    = 1'b1;
    o_dq_oe   = 1'b0;
    o_ma      = '0;
    o_dtack_n = 1'b1;
    case (r_state)
      ST_ROW: begin
        o_ras_n = 1'b0;
        o_ma    = r_row;
        o_we_n  = !w_wr_en;
        o_dq_oe = w_wr_en;
      end
      ST_COL: begin
        o_ras_n = 1'b0;
        o_ma    = r_col;
        o_we_n  = !w_wr_en;
        o_dq_oe = w_wr_en;
        o_cas_n = w_cas_sel_n;
      end
      ST_ACK:     o_dtack_n = 1'b0;
      ST_REF_CAS: o_cas_n = '0;
      ST_REF_RAS: begin
        o_ras_n = 1'b0;
        o_cas_n = '0;
      end
      default: ;
    endcase
  end

  assign o_dq_o = r_wd;
  assign o_rd   = r_rd;
  assign o_wpro = r_wpro;

endmodule

// File: tb/tb_amiga_wcs_dram_ctrl.sv
// Directed bench for amiga_wcs_dram_ctrl at default parameters; inputs change
// and outputs are sampled on the falling clock edge.
module tb_amiga_wcs_dram_ctrl;

  localparam int DIV = 109;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, rw = 1'b1, uds_n = 1'b1, lds_n = 1'b1, wp_set = 1'b0;
  logic [16:0] a = '0;
  logic [15:0] wd = '0, dq_i = '0;
  logic [15:0] rd, dq_o;
  logic        dtack_n, wpro, ras_n, we_n, dq_oe;
  logic [7:0]  ma;
  logic [3:0]  cas_n;

  int checks = 0, errors = 0, ref_cnt = 0, cyc = 0;

  amiga_wcs_dram_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_a(a), .i_rw(rw),
    .i_uds_n(uds_n), .i_lds_n(lds_n), .i_wd(wd), .o_rd(rd), .o_dtack_n(dtack_n),
    .i_wp_set(wp_set), .o_wpro(wpro), .o_ma(ma), .o_ras_n(ras_n), .o_cas_n(cas_n),
    .o_we_n(we_n), .o_dq_o(dq_o), .o_dq_oe(dq_oe), .i_dq_i(dq_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && cas_n == 4'h0 && ras_n) ref_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_req(input logic [16:0] addr, input logic r, input logic u,
                           input logic l, input logic [15:0] d);
    a = addr; rw = r; uds_n = u; lds_n = l; wd = d; req = 1'b1;
  endtask

  task automatic end_req(input int n);
    req = 1'b0;
    repeat (n) step();
  endtask

  task automatic sync_refresh();
    int n;
    n = 0;
    while (!(cas_n == 4'h0 && ras_n) && n < 3*DIV) begin
      step();
      n++;
    end
    checks++;
    if (n >= 3*DIV) begin
      errors++;
      $display("FAIL sync_refresh: no refresh in %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if ({ras_n, we_n, dtack_n} !== 3'b111) begin errors++;
      $display("FAIL reset_strobes: ras_n/we_n/dtack_n=%b expected 111", {ras_n, we_n, dtack_n}); end
    checks++; if (cas_n !== 4'hF) begin errors++; $display("FAIL reset_cas: cas_n=%h expected f", cas_n); end
    checks++; if (ma !== 8'h00) begin errors++; $display("FAIL reset_ma: ma=%h expected 00", ma); end
    checks++; if (rd !== 16'h0) begin errors++; $display("FAIL reset_rd: rd=%h expected 0000", rd); end
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: dq_oe=%b expected 0", dq_oe); end
    checks++; if (wpro !== 1'b0) begin errors++; $display("FAIL reset_wpro: wpro=%b expected 0", wpro); end
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    int k_ack;
    sync_refresh(); repeat (6) step();
    dq_i = 16'hBEEF;
    start_req({1'b1, 8'h3C, 8'hA5}, 1'b1, 1'b0, 1'b0, 16'h0);
    k_ack = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin checks++; if (ma !== 8'h3C || ras_n !== 1'b0 || cas_n !== 4'hF) begin errors++;
        $display("FAIL read_row: ma=%h ras_n=%b cas_n=%h expected 3c 0 f", ma, ras_n, cas_n); end end
      if (k == 3) begin checks++; if (ma !== 8'hA5 || cas_n !== 4'b0011 || we_n !== 1'b1) begin errors++;
        $display("FAIL read_col: ma=%h cas_n=%b we_n=%b expected a5 0011 1", ma, cas_n, we_n); end end
      if (k == 5) begin checks++; if (rd !== 16'hBEEF) begin errors++;
        $display("FAIL read_data: rd=%h expected beef", rd); end end
      if (dtack_n == 1'b0 && k_ack == 0) k_ack = k;
    end
    checks++; if (k_ack != 5) begin errors++; $display("FAIL read_latency: dtack at %0d expected 5", k_ack); end
    end_req(3);
  endtask

  task automatic test_write();
    int k_ack;
    sync_refresh(); repeat (6) step();
    start_req({1'b0, 8'h11, 8'h22}, 1'b0, 1'b0, 1'b1, 16'h1234);
    k_ack = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin checks++;
        if (we_n !== 1'b0 || dq_oe !== 1'b1 || dq_o !== 16'h1234 || cas_n !== 4'hF) begin errors++;
          $display("FAIL write_setup: we_n=%b dq_oe=%b dq_o=%h cas_n=%h expected 0 1 1234 f",
                   we_n, dq_oe, dq_o, cas_n); end end
      if (k == 3) begin checks++; if (cas_n !== 4'b1101 || we_n !== 1'b0) begin errors++;
        $display("FAIL write_cas: cas_n=%b we_n=%b expected 1101 0", cas_n, we_n); end end
      if (dtack_n == 1'b0 && k_ack == 0) k_ack = k;
    end
    checks++; if (k_ack != 5) begin errors++; $display("FAIL write_latency: dtack at %0d expected 5", k_ack); end
    end_req(3);
  endtask

  task automatic test_strobes_off();
    int k_ack;
    logic bad;
    sync_refresh(); repeat (6) step();
    start_req({1'b1, 8'h02, 8'h03}, 1'b1, 1'b1, 1'b1, 16'h0);
    k_ack = 0; bad = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (cas_n !== 4'hF) bad = 1'b1;
      if (dtack_n == 1'b0 && k_ack == 0) k_ack = k;
    end
    checks++; if (bad) begin errors++; $display("FAIL nostrobe_cas: cas_n went low, expected f"); end
    checks++; if (k_ack != 5) begin errors++; $display("FAIL nostrobe_ack: dtack at %0d expected 5", k_ack); end
    end_req(3);
  endtask

  task automatic test_abort();
    sync_refresh(); repeat (6) step();
    start_req({1'b0, 8'h44, 8'h45}, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 2) req = 1'b0;
      if (k == 5) begin checks++; if (dtack_n !== 1'b0) begin errors++;
        $display("FAIL abort_ack: dtack_n=%b expected 0", dtack_n); end end
      if (k == 6) begin checks++; if (dtack_n !== 1'b1) begin errors++;
        $display("FAIL abort_release: dtack_n=%b expected 1", dtack_n); end end
    end
    repeat (2) step();
  endtask

  task automatic test_reset_mid_write();
    int k_ack;
    sync_refresh(); repeat (6) step();
    start_req({1'b0, 8'h21, 8'h43}, 1'b0, 1'b0, 1'b0, 16'hCAFE);
    repeat (3) step();
    checks++; if (cas_n !== 4'b1100 || we_n !== 1'b0 || dq_oe !== 1'b1) begin errors++;
      $display("FAIL rstwr_col: cas_n=%b we_n=%b dq_oe=%b expected 1100 0 1", cas_n, we_n, dq_oe); end
    rst_n = 1'b0; req = 1'b0;
    #1;
    checks++; if ({ras_n, we_n, dtack_n} !== 3'b111 || cas_n !== 4'hF || dq_oe !== 1'b0) begin errors++;
      $display("FAIL rstwr_strobes: ras_n/we_n/dtack_n=%b cas_n=%h dq_oe=%b expected 111 f 0",
               {ras_n, we_n, dtack_n}, cas_n, dq_oe); end
    step();
    rst_n = 1'b1;
    dq_i = 16'h0F0F;
    start_req({1'b1, 8'h01, 8'h02}, 1'b1, 1'b0, 1'b0, 16'h0);
    k_ack = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (dtack_n == 1'b0 && k_ack == 0) k_ack = k;
    end
    checks++; if (k_ack != 5 || rd !== 16'h0F0F) begin errors++;
      $display("FAIL rstwr_after: dtack at %0d rd=%h expected 5 0f0f", k_ack, rd); end
    end_req(3);
  endtask

  task automatic test_wp();
    int k_ack;
    logic bad;
    sync_refresh(); repeat (6) step();
    start_req({1'b1, 8'h66, 8'h77}, 1'b0, 1'b1, 1'b0, 16'h5555);
    k_ack = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) wp_set = 1'b1;
      if (k == 2) begin
        wp_set = 1'b0;
        checks++; if (wpro !== 1'b1) begin errors++; $display("FAIL wp_set: wpro=%b expected 1", wpro); end
      end
      if (k == 3) begin checks++; if (cas_n !== 4'b1011 || we_n !== 1'b0) begin errors++;
        $display("FAIL wp_midwrite: cas_n=%b we_n=%b expected 1011 0", cas_n, we_n); end end
      if (dtack_n == 1'b0 && k_ack == 0) k_ack = k;
    end
    checks++; if (k_ack != 5) begin errors++; $display("FAIL wp_midack: dtack at %0d expected 5", k_ack); end
    end_req(3);
    start_req({1'b0, 8'h12, 8'h34}, 1'b0, 1'b0, 1'b0, 16'hAAAA);
    k_ack = 0; bad = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (cas_n !== 4'hF || we_n !== 1'b1 || dq_oe !== 1'b0) bad = 1'b1;
      if (dtack_n == 1'b0 && k_ack == 0) k_ack = k;
    end
    checks++; if (bad) begin errors++; $display("FAIL wp_drop: cas/we/oe active, expected all inactive"); end
    checks++; if (k_ack != 5) begin errors++; $display("FAIL wp_ack: dtack at %0d expected 5", k_ack); end
    end_req(3);
  endtask

  task automatic test_refresh_priority();
    int k_ack;
    sync_refresh(); step(); sync_refresh();
    repeat (DIV - 1) step();
    dq_i = 16'h1357;
    start_req({1'b0, 8'h55, 8'h66}, 1'b1, 1'b0, 1'b0, 16'h0);
    k_ack = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) begin checks++; if (cas_n !== 4'h0 || ras_n !== 1'b1) begin errors++;
        $display("FAIL prio_refcas: cas_n=%h ras_n=%b expected 0 1", cas_n, ras_n); end end
      if (k == 2) begin checks++; if (cas_n !== 4'h0 || ras_n !== 1'b0) begin errors++;
        $display("FAIL prio_refras: cas_n=%h ras_n=%b expected 0 0", cas_n, ras_n); end end
      if (k == 8) begin checks++; if (ma !== 8'h55 || ras_n !== 1'b0) begin errors++;
        $display("FAIL prio_row: ma=%h ras_n=%b expected 55 0", ma, ras_n); end end
      if (dtack_n == 1'b0 && k_ack == 0) k_ack = k;
    end
    checks++; if (k_ack != 12 || rd !== 16'h1357) begin errors++;
      $display("FAIL prio_access: dtack at %0d rd=%h expected 12 1357", k_ack, rd); end
    end_req(3);
  endtask

  task automatic test_back_to_back();
    int start_ref, cyc0, n_rd, w;
    sync_refresh(); step();
    start_ref = ref_cnt; cyc0 = cyc; n_rd = 0;
    while (cyc - cyc0 < 240) begin
      dq_i = 16'h5A00 + 16'(n_rd);
      start_req({n_rd[0], 8'h30 + 8'(n_rd), 8'hC0}, 1'b1, 1'b0, 1'b0, 16'h0);
      w = 0;
      while (dtack_n !== 1'b0 && w < 40) begin step(); w++; end
      checks++;
      if (w >= 40) begin errors++; $display("FAIL b2b_timeout: read %0d no dtack in 40 cycles", n_rd); end
      else if (rd !== 16'h5A00 + 16'(n_rd)) begin errors++;
        $display("FAIL b2b_data: read %0d rd=%h expected %h", n_rd, rd, 16'h5A00 + 16'(n_rd)); end
      end_req(1);
      n_rd++;
    end
    repeat (3) step();
    checks++; if (ref_cnt - start_ref != 2) begin errors++;
      $display("FAIL b2b_refresh: %0d refreshes expected 2", ref_cnt - start_ref); end
  endtask

  task automatic test_idle_refresh();
    int start_ref;
    sync_refresh(); step();
    start_ref = ref_cnt;
    repeat (10*DIV) step();
    checks++; if (ref_cnt - start_ref != 10) begin errors++;
      $display("FAIL idle_refresh: %0d refreshes expected 10", ref_cnt - start_ref); end
  endtask

  task automatic test_wp_clear();
    checks++; if (wpro !== 1'b1) begin errors++; $display("FAIL wp_sticky: wpro=%b expected 1", wpro); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (wpro !== 1'b0) begin errors++; $display("FAIL wp_clear: wpro=%b expected 0", wpro); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_strobes_off();
    test_abort();
    test_reset_mid_write();
    test_wp();
    test_refresh_priority();
    test_back_to_back();
    test_idle_refresh();
    test_wp_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
